// File: rtl/bist_pkg.sv
// Shared definitions for the logic-BIST block set (controller, LFSR, MISR).
//
// Contents:
//   bist_state_e    - controller FSM state encoding
//   BIST_SIG_W      - default MISR signature width
//   BIST_CNT_W      - default controller counter width
//   BIST_GOLDEN_SIG - default fault-free signature
package bist_pkg;

    localparam int BIST_SIG_W = 21;
    localparam int BIST_CNT_W = 16;
    localparam logic [BIST_SIG_W-1:0] BIST_GOLDEN_SIG = 21'h000000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        RUN     = 3'd2,
        DRAIN   = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } bist_state_e;

endpackage

// File: rtl/bist_counter.sv
// Loadable down-counter shared by the RUN and DRAIN phases of the BIST
// controller. Load has priority over decrement; decrement saturates at zero.
//
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - synchronous active-high reset, clears the count
//   load_i     - load load_val_i into the count
//   load_val_i - value to load
//   dec_i      - decrement the count by one
//   count_o    - current count
//   zero_o     - count is zero
module bist_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/bist_controller.sv
// Logic-BIST session sequencer. Seeds the pattern LFSR, clears the MISR,
// runs N_PATTERNS pattern cycles, lets the MISR absorb DRAIN_CYCLES more
// responses, then freezes the MISR and compares its signature to GOLDEN_SIG.
//
// Control protocol: bist_start is a level sampled only in IDLE or DONE
// (ignored, not queued, while busy). done is the result-valid flag; pass and
// fail are only meaningful while done=1 and are both 0 otherwise. bist_abort
// returns a busy session to IDLE on the next edge and beats both start and
// phase completion; it is ignored in IDLE and DONE.
//
// Ports:
//   CLK, RST    - clock and synchronous active-high reset
//   bist_start  - start request
//   bist_abort  - abort the current session
//   signature   - MISR output
//   lfsr_load   - one-cycle LFSR seed load pulse
//   lfsr_en     - LFSR advance enable
//   misr_clear  - one-cycle MISR clear pulse
//   bist_end    - MISR hold (1) / absorb (0)
//   test_mode   - CUT input mux selects LFSR patterns
//   busy        - session in progress (INIT..COMPARE)
//   done        - result valid
//   pass, fail  - comparison result, valid while done=1
//   dbg_state   - current FSM state, for observation only
//
// Every output is decoded from registered state or is a register, so there is
// no combinational path from any input to any output.
module bist_controller
    import bist_pkg::*;
#(
    parameter int              N_PATTERNS   = 1000,
    parameter int              DRAIN_CYCLES = 2,
    parameter int              SIG_W        = BIST_SIG_W,
    parameter logic [SIG_W-1:0] GOLDEN_SIG  = SIG_W'(BIST_GOLDEN_SIG),
    parameter int              CNT_W        = BIST_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             bist_start,
    input  logic             bist_abort,
    input  logic [SIG_W-1:0] signature,
    output logic             lfsr_load,
    output logic             lfsr_en,
    output logic             misr_clear,
    output logic             bist_end,
    output logic             test_mode,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output bist_state_e      dbg_state
);

    // Counter preload values: a phase of L cycles counts L-1 down to 0.
    localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(N_PATTERNS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD =
        (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

    bist_state_e      state_q, state_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;
    logic             in_session;

    bist_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .count_o    (cnt_value),
        .zero_o     (cnt_zero)
    );

    assign in_session = (state_q == INIT) || (state_q == RUN) ||
                        (state_q == DRAIN) || (state_q == COMPARE);

    // Next-state, counter control and result registers.
    always_comb begin
        state_d      = state_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bist_start) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                cnt_load     = 1'b1;
                cnt_load_val = RUN_LOAD;
                state_d      = RUN;
            end
            RUN: begin
                if (cnt_zero) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = COMPARE;
                    end else begin
                        cnt_load     = 1'b1;
                        cnt_load_val = DRAIN_LOAD;
                        state_d      = DRAIN;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_zero) begin
                    state_d = COMPARE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            COMPARE: begin
                pass_d  = (signature == GOLDEN_SIG);
                fail_d  = (signature != GOLDEN_SIG);
                state_d = DONE;
            end
            DONE: begin
                // Restart drops the old result on the same edge it enters INIT.
                if (bist_start) begin
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    state_d = INIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the active phase decided.
        if (bist_abort && in_session) begin
            state_d  = IDLE;
            pass_d   = 1'b0;
            fail_d   = 1'b0;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        lfsr_load  = 1'b0;
        lfsr_en    = 1'b0;
        misr_clear = 1'b0;
        bist_end   = 1'b1;
        test_mode  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
            end
            INIT: begin
                lfsr_load  = 1'b1;
                misr_clear = 1'b1;
                test_mode  = 1'b1;
                busy       = 1'b1;
            end
            RUN: begin
                lfsr_en   = 1'b1;
                bist_end  = 1'b0;
                test_mode = 1'b1;
                busy      = 1'b1;
            end
            DRAIN: begin
                bist_end  = 1'b0;
                test_mode = 1'b1;
                busy      = 1'b1;
            end
            COMPARE: begin
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pass      = pass_q;
    assign fail      = fail_q;
    assign dbg_state = state_q;

endmodule
